// File: rtl/i2c_regfile_arbiter.sv
// i2c_regfile_arbiter: 16-byte register file shared by the I2C slave engine (S)
// and a local host port (H). Fixed priority to S with a starvation guard for H,
// one single-byte access in flight at a time, optional write-protect on S writes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access in flight; arbitrate s_req/h_req
// ACC_S | S command captured; memory access at the edge leaving it
// ACC_H | H command captured; memory access at the edge leaving it
// ACK   | ack pulse to the owning port; req ignored so no double grant
module i2c_regfile_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int STARVE_LIM = 3,
    parameter logic [ADDR_W-1:0] WP_LO = 4'hC,
    parameter logic [ADDR_W-1:0] WP_HI = 4'hF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              s_req,
    input  logic              s_we,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              s_ack,
    output logic [DATA_W-1:0] s_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_ack,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              wp_en,
    output logic              wp_hit,
    output logic              busy
);

    localparam int SC_W = $clog2(STARVE_LIM + 1);
    localparam logic [SC_W-1:0] SC_LIM = SC_W'(STARVE_LIM);

    typedef enum logic [1:0] {IDLE, ACC_S, ACC_H, ACK} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              own_h;
    logic              wp_drop;
    logic [SC_W-1:0]   starve_cnt;
    logic              grant_s, grant_h;
    logic              in_range, wp_window, wp_block;
    logic [DATA_W-1:0] rd_val;

    // Address qualification of the captured command
    always_comb begin
        in_range  = 32'(cmd_addr) < 32'(DEPTH);
        wp_window = (32'(cmd_addr) >= 32'(WP_LO)) && (32'(cmd_addr) <= 32'(WP_HI));
        wp_block  = !own_h && wp_en && wp_window;
        rd_val    = in_range ? mem[cmd_addr] : '0;
    end

    // Next-state and grant decode; H only wins a tie once S has starved it
    always_comb begin
        state_nxt = state;
        grant_s   = 1'b0;
        grant_h   = 1'b0;
        case (state)
            IDLE: begin
                if (h_req && (!s_req || starve_cnt == SC_LIM)) begin
                    grant_h   = 1'b1;
                    state_nxt = ACC_H;
                end else if (s_req) begin
                    grant_s   = 1'b1;
                    state_nxt = ACC_S;
                end
            end
            ACC_S, ACC_H: state_nxt = ACK;
            ACK:          state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Command capture at the grant edge and starvation counter
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            own_h      <= 1'b0;
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_h) begin
                own_h      <= 1'b1;
                cmd_we     <= h_we;
                cmd_addr   <= h_addr;
                cmd_wdata  <= h_wdata;
                starve_cnt <= '0;
            end else if (grant_s) begin
                own_h     <= 1'b0;
                cmd_we    <= s_we;
                cmd_addr  <= s_addr;
                cmd_wdata <= s_wdata;
                if (h_req && starve_cnt != SC_LIM) starve_cnt <= starve_cnt + 1'b1;
            end
            if (!h_req) starve_cnt <= '0;
        end
    end

    // Memory access; read data registers hold until the next read on that port
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            s_rdata <= '0;
            h_rdata <= '0;
            wp_drop <= 1'b0;
        end else if (state == ACC_S || state == ACC_H) begin
            wp_drop <= cmd_we && wp_block;
            if (cmd_we) begin
                if (in_range && !wp_block) mem[cmd_addr] <= cmd_wdata;
            end else if (own_h) begin
                h_rdata <= rd_val;
            end else begin
                s_rdata <= rd_val;
            end
        end
    end

    assign s_ack  = (state == ACK) && !own_h;
    assign h_ack  = (state == ACK) && own_h;
    assign wp_hit = s_ack && wp_drop;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_i2c_regfile_arbiter.sv
// Bench for i2c_regfile_arbiter: two instances (DEPTH 16 and DEPTH 12) share
// stimulus; a countdown-based behavioural model predicts every output cycle.
module tb_i2c_regfile_arbiter;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       s_req = 1'b0, s_we = 1'b0, h_req = 1'b0, h_we = 1'b0, wp_en = 1'b0;
    logic [3:0] s_addr = '0, h_addr = '0;
    logic [7:0] s_wdata = '0, h_wdata = '0;

    logic       s_ack_a, h_ack_a, wp_hit_a, busy_a;
    logic [7:0] s_rdata_a, h_rdata_a;
    logic       s_ack_b, h_ack_b, wp_hit_b, busy_b;
    logic [7:0] s_rdata_b, h_rdata_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int s_ack_cyc = 0, h_ack_cyc = 0;
    string ack_log = "";

    localparam int LIM = 3;

    always #10 Clk = ~Clk;

    i2c_regfile_arbiter dut_a (
        .Clk(Clk), .Rst_n(Rst_n),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack_a), .s_rdata(s_rdata_a),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_ack(h_ack_a), .h_rdata(h_rdata_a),
        .wp_en(wp_en), .wp_hit(wp_hit_a), .busy(busy_a)
    );

    i2c_regfile_arbiter #(.DEPTH(12)) dut_b (
        .Clk(Clk), .Rst_n(Rst_n),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack_b), .s_rdata(s_rdata_b),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_ack(h_ack_b), .h_rdata(h_rdata_b),
        .wp_en(wp_en), .wp_hit(wp_hit_b), .busy(busy_b)
    );

    // ---------------- behavioural model ----------------
    // m_left counts cycles until the arbiter is free again: 2 = access pending,
    // 1 = ack cycle, 0 = free.
    int         m_left = 0;
    int         m_starve = 0;
    bit         m_own_h = 0, m_we = 0, m_wp = 0;
    logic [3:0] m_addr = '0;
    logic [7:0] m_wdata = '0;
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] ex_srd_a = '0, ex_hrd_a = '0, ex_srd_b = '0, ex_hrd_b = '0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_left = 0; m_starve = 0; m_own_h = 0; m_wp = 0;
            for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
            ex_srd_a = '0; ex_hrd_a = '0; ex_srd_b = '0; ex_hrd_b = '0;
        end else if (m_left == 0) begin
            if (h_req && (!s_req || m_starve == LIM)) begin
                m_own_h = 1; m_we = h_we; m_addr = h_addr; m_wdata = h_wdata;
                m_starve = 0; m_left = 2;
            end else if (s_req) begin
                m_own_h = 0; m_we = s_we; m_addr = s_addr; m_wdata = s_wdata;
                if (h_req) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
                m_left = 2;
            end
            if (!h_req) m_starve = 0;
        end else if (m_left == 2) begin
            bit prot;
            prot = !m_own_h && wp_en && (m_addr >= 4'hC);
            m_wp = m_we && prot;
            if (m_we) begin
                if (!prot) begin
                    mem_a[m_addr] = m_wdata;
                    if (int'(m_addr) < 12) mem_b[m_addr] = m_wdata;
                end
            end else if (m_own_h) begin
                ex_hrd_a = mem_a[m_addr];
                ex_hrd_b = (int'(m_addr) < 12) ? mem_b[m_addr] : 8'h00;
            end else begin
                ex_srd_a = mem_a[m_addr];
                ex_srd_b = (int'(m_addr) < 12) ? mem_b[m_addr] : 8'h00;
            end
            m_left = 1;
        end else begin
            m_left = 0;
        end
    end

    always @(posedge Clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge Clk) begin
        logic ex_busy, ex_sack, ex_hack, ex_wp;
        ex_busy = (m_left != 0);
        ex_sack = (m_left == 1) && !m_own_h;
        ex_hack = (m_left == 1) && m_own_h;
        ex_wp   = ex_sack && m_wp;
        chk("cycle_a", {12'h0, busy_a, s_ack_a, h_ack_a, wp_hit_a, s_rdata_a, h_rdata_a},
                       {12'h0, ex_busy, ex_sack, ex_hack, ex_wp, ex_srd_a, ex_hrd_a});
        chk("cycle_b", {12'h0, busy_b, s_ack_b, h_ack_b, wp_hit_b, s_rdata_b, h_rdata_b},
                       {12'h0, ex_busy, ex_sack, ex_hack, ex_wp, ex_srd_b, ex_hrd_b});
        if (s_ack_a) begin ack_log = {ack_log, "S"}; s_ack_cyc = cyc; end
        if (h_ack_a) begin ack_log = {ack_log, "H"}; h_ack_cyc = cyc; end
    end

    // ---------------- requester tasks (entered at posedge + #1) ----------------
    task automatic s_access(input bit we, input logic [3:0] a, input logic [7:0] d, input bit keep,
                            output logic [7:0] rda, output logic [7:0] rdb, output logic wph);
        bit seen = 0;
        rda = '0; rdb = '0; wph = 1'b0;
        s_req = 1; s_we = we; s_addr = a; s_wdata = d;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge Clk);
            if (s_ack_a) begin seen = 1; rda = s_rdata_a; rdb = s_rdata_b; wph = wp_hit_a; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL s_ack_timeout actual=none required=ack within 60 cycles");
        end
        @(posedge Clk); #1;
        if (!keep) s_req = 0;
    endtask

    task automatic h_access(input bit we, input logic [3:0] a, input logic [7:0] d, input bit keep,
                            output logic [7:0] rda, output logic [7:0] rdb, output logic wph);
        bit seen = 0;
        rda = '0; rdb = '0; wph = 1'b0;
        h_req = 1; h_we = we; h_addr = a; h_wdata = d;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge Clk);
            if (h_ack_a) begin seen = 1; rda = h_rdata_a; rdb = h_rdata_b; wph = wp_hit_a; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL h_ack_timeout actual=none required=ack within 60 cycles");
        end
        @(posedge Clk); #1;
        if (!keep) h_req = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0] ra, rb, ra2, rb2;
        logic       wp, wp2;
        int         t0, lat;
        bit         s_done, h_done;

        repeat (2) @(negedge Clk);
        chk("reset_outputs", {12'h0, busy_a, s_ack_a, h_ack_a, wp_hit_a, s_rdata_a, h_rdata_a}, 32'h0);
        @(posedge Clk); #3 Rst_n = 1;
        @(posedge Clk); #1;

        // 1: H write then S read of the same register
        t0 = cyc;
        h_access(1, 4'h3, 8'h5A, 0, ra, rb, wp);
        lat = h_ack_cyc - t0;
        chk("t1_h_ack_latency", lat, 2);
        s_access(0, 4'h3, 8'h00, 0, ra, rb, wp);
        chk("t1_s_rdata_a", ra, 8'h5A);
        chk("t1_s_rdata_b", rb, 8'h5A);
        chk("t1_ack_one_cycle", {s_ack_a, busy_a}, 2'b00);

        // 2: simultaneous reads, S first, H three cycles later
        ack_log = "";
        fork
            s_access(0, 4'h3, 8'h00, 0, ra, rb, wp);
            h_access(0, 4'h3, 8'h00, 0, ra2, rb2, wp2);
        join
        total++;
        if (ack_log != "SH") begin bad++; $display("FAIL t2_order actual=%s required=SH", ack_log); end
        lat = h_ack_cyc - s_ack_cyc;
        chk("t2_h_after_s", lat, 3);
        chk("t2_h_rdata", ra2, 8'h5A);

        // 3: S back-to-back with H pending -> starvation guard
        ack_log = "";
        fork
            for (int i = 0; i < 6; i++) s_access(1, 4'(i), 8'(8'h10 + i), i < 5, ra, rb, wp);
            begin
                h_access(0, 4'h3, 8'h00, 1, ra2, rb2, wp2);
                h_access(0, 4'h4, 8'h00, 0, ra2, rb2, wp2);
            end
        join
        total++;
        if (ack_log != "SSSHSSSH") begin
            bad++; $display("FAIL t3_grant_order actual=%s required=SSSHSSSH", ack_log);
        end
        chk("t3_h_rdata_reg4", ra2, 8'h14);

        // 4: write protect on S only
        wp_en = 1;
        s_access(1, 4'hD, 8'hFF, 0, ra, rb, wp);
        chk("t4_wp_hit", wp, 1'b1);
        h_access(0, 4'hD, 8'h00, 0, ra, rb, wp);
        chk("t4_h_read_old", ra, 8'h00);
        h_access(1, 4'hD, 8'h77, 0, ra, rb, wp);
        chk("t4_h_write_no_wp", wp, 1'b0);
        s_access(0, 4'hD, 8'h00, 0, ra, rb, wp);
        chk("t4_s_read_a", ra, 8'h77);
        chk("t4_s_read_b_unimpl", rb, 8'h00);
        wp_en = 0;

        // 5: unimplemented address on the DEPTH=12 instance
        s_access(1, 4'hE, 8'hAB, 0, ra, rb, wp);
        s_access(0, 4'hE, 8'h00, 0, ra, rb, wp);
        chk("t5_read_b_unimpl", rb, 8'h00);
        chk("t5_read_a_impl", ra, 8'hAB);

        // 6: reset during ACC_H of an H write
        h_req = 1; h_we = 1; h_addr = 4'h2; h_wdata = 8'hC3;
        @(posedge Clk); #2;
        chk("t6_in_access", busy_a, 1'b1);
        Rst_n = 0; h_req = 0;
        repeat (2) @(posedge Clk);
        #3 Rst_n = 1;
        @(negedge Clk);
        chk("t6_busy_after_reset", busy_a, 1'b0);
        @(posedge Clk); #1;
        s_access(0, 4'h2, 8'h00, 0, ra, rb, wp);
        chk("t6_reg2_cleared", ra, 8'h00);
        s_access(0, 4'h3, 8'h00, 0, ra, rb, wp);
        chk("t6_reg3_cleared", ra, 8'h00);

        // Random traffic on both ports with wp_en toggling
        s_done = 0; h_done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int g;
                    s_access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), 0, ra, rb, wp);
                    g = $urandom_range(0, 3);
                    if (g != 0) begin repeat (g) @(posedge Clk); #1; end
                end
                s_done = 1;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    int g;
                    h_access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), 0, ra2, rb2, wp2);
                    g = $urandom_range(0, 3);
                    if (g != 0) begin repeat (g) @(posedge Clk); #1; end
                end
                h_done = 1;
            end
            begin
                for (int n = 0; n < 5000 && !(s_done && h_done); n++) begin
                    @(posedge Clk); #1;
                    if ($urandom_range(0, 7) == 0) wp_en = ~wp_en;
                end
            end
        join

        repeat (3) @(posedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
